slice_stream_reader: RTL

- Upstream feeder for the LED driver controller. Reads one slice from the slice RAM and emits one bit per driver per cycle on framebuffer_dat, with a one-cycle framebuffer_sync pulse at each slice start.
- Its line period matches the controller's STREAM SCLK counter: BLANKING_TIME idle cycles, BITS*CHANNELS data cycles, then 1 pad cycle.
- Handles RAM read prefetch, MSB-first bit serialisation, multiplex-line sequencing and back-to-back slice chaining.

---
 rtl/slice_stream_reader_if.sv | 26 ++
 rtl/slice_stream_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/slice_stream_reader_if.sv
// RAM read port and framebuffer output bundle for slice_stream_reader.
// master = the reader itself, slave = RAM / LED driver side.
interface slice_stream_reader_if #(
   parameter int N_DRIVERS = 30,
   parameter int BITS      = 9,
   parameter int ADDR_W    = 9
);
   logic [ADDR_W-1:0]         ram_addr;
   logic [N_DRIVERS*BITS-1:0] ram_rdata;
   logic [N_DRIVERS-1:0]      framebuffer_dat;
   logic                      framebuffer_sync;

   modport master (
      output ram_addr,
      output framebuffer_dat,
      output framebuffer_sync,
      input  ram_rdata
   );

   modport slave (
      input  ram_addr,
      input  framebuffer_dat,
      input  framebuffer_sync,
      output ram_rdata
   );
endinterface

// File: rtl/slice_stream_reader.sv
// Reads a slice from the slice RAM and serialises it MSB-first, one bit per driver per cycle.
// Optional test pattern generator enabled by defining SLICE_TEST_PATTERN_EN.
module slice_stream_reader #(
   parameter int BLANKING_TIME = 80,
   parameter int N_DRIVERS     = 30,
   parameter int BITS          = 9,
   parameter int CHANNELS      = 48,
   parameter int MUX_LINES     = 8
) (
   input  logic clk_33,
   input  logic rst,
   input  logic slice_start,
`ifdef SLICE_TEST_PATTERN_EN
   input  logic test_mode,
`endif
   slice_stream_reader_if.master bus,
   output logic busy,
   output logic underrun,
   output logic overrun
);
   localparam int ADDR_W      = $clog2(MUX_LINES*CHANNELS);
   localparam int SHIFT_LEN   = BITS*CHANNELS;
   localparam int PERIOD      = BLANKING_TIME + SHIFT_LEN + 1;
   localparam int LC_W        = $clog2(PERIOD);
   localparam int LINE_W      = $clog2(MUX_LINES > 1 ? MUX_LINES : 2);
   localparam int BIT_W       = $clog2(BITS > 1 ? BITS : 2);
   localparam int WORD_W      = N_DRIVERS*BITS;
   localparam int FETCH_FIRST = BLANKING_TIME - 2;
   localparam int FETCH_END   = FETCH_FIRST + SHIFT_LEN;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SYNC = 2'd1;
   localparam logic [1:0] S_LINE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [LC_W-1:0]   lc_q, lc_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [ADDR_W-1:0] lineBase_q, lineBase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BIT_W-1:0]  fBit_q, fBit_d;
   logic              pending_q, pending_d;
   logic              underrun_q, underrun_d;
   logic              overrun_q, overrun_d;
   logic              load_q;
   logic              act_q;
   logic [WORD_W-1:0] shreg_q;
   logic [N_DRIVERS-1:0] dat_q;

   logic [ADDR_W-1:0]    nextBase;
   logic [WORD_W-1:0]    loadWord, src, shNext;
   logic [N_DRIVERS-1:0] datNext;
   logic isLine, lastLc, lastLine, lastPad, chain, fActive, fetch;

`ifdef SLICE_TEST_PATTERN_EN
   logic testMode_q, testMode_d;
   logic tpHit_q;
`endif

   assign isLine   = (state_q == S_LINE);
   assign lastLc   = (lc_q == LC_W'(PERIOD-1));
   assign lastLine = (line_q == LINE_W'(MUX_LINES-1));
   assign lastPad  = isLine && lastLc && lastLine;
   assign chain    = lastPad && (pending_q || slice_start);
   assign fActive  = isLine && (lc_q >= LC_W'(FETCH_FIRST)) && (lc_q < LC_W'(FETCH_END));
   assign fetch    = fActive && (fBit_q == '0);
   assign nextBase = lineBase_q + ADDR_W'(CHANNELS);

   // Sequencing: the fetch window runs two cycles ahead of the shift window, one fetch per
   // BITS cycles; the address is preloaded to channel CHANNELS-1 and walks down after each fetch.
   always_comb begin
      state_d    = state_q;
      lc_d       = lc_q;
      line_d     = line_q;
      lineBase_d = lineBase_q;
      addr_d     = addr_q;
      pending_d  = pending_q;
      underrun_d = underrun_q;
      overrun_d  = overrun_q;
      fBit_d     = '0;
`ifdef SLICE_TEST_PATTERN_EN
      testMode_d = testMode_q;
`endif
      if (fActive) begin
         fBit_d = (fBit_q == BIT_W'(BITS-1)) ? '0 : fBit_q + BIT_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (slice_start) begin
               state_d = S_SYNC;
`ifdef SLICE_TEST_PATTERN_EN
               testMode_d = test_mode;
`endif
            end
         end
         S_SYNC: begin
            state_d    = S_LINE;
            lc_d       = '0;
            line_d     = '0;
            lineBase_d = '0;
            addr_d     = ADDR_W'(CHANNELS-1);
         end
         S_LINE: begin
            if (lastLc) begin
               lc_d = '0;
               if (!lastLine) begin
                  line_d     = line_q + LINE_W'(1);
                  lineBase_d = nextBase;
                  addr_d     = nextBase + ADDR_W'(CHANNELS-1);
               end else if (chain) begin
                  line_d     = '0;
                  lineBase_d = '0;
                  addr_d     = ADDR_W'(CHANNELS-1);
`ifdef SLICE_TEST_PATTERN_EN
                  testMode_d = test_mode;
`endif
               end else begin
                  state_d    = S_IDLE;
                  underrun_d = 1'b1;
               end
            end else begin
               lc_d = lc_q + LC_W'(1);
               if (fetch && (addr_q != lineBase_q)) begin
                  addr_d = addr_q - ADDR_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A start landing on the final pad chains directly; a held pending start is consumed there.
      if (lastPad) begin
         pending_d = pending_q & slice_start;
      end else if (slice_start && (state_q != S_IDLE)) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end
   end

   // Per-driver MSB-first shifting; the cycle after a fetch takes fresh data straight from RAM.
   always_comb begin
`ifdef SLICE_TEST_PATTERN_EN
      if (testMode_q) begin
         for (int d = 0; d < N_DRIVERS; d++) begin
            loadWord[d*BITS +: BITS] = {BITS{tpHit_q}};
         end
      end else begin
         loadWord = bus.ram_rdata;
      end
`else
      loadWord = bus.ram_rdata;
`endif
      src = load_q ? loadWord : shreg_q;
      for (int d = 0; d < N_DRIVERS; d++) begin
         datNext[d]             = src[d*BITS + BITS - 1];
         shNext[d*BITS +: BITS] = {src[d*BITS +: BITS-1], 1'b0};
      end
   end

   always_ff @(posedge clk_33) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lc_q       <= '0;
         line_q     <= '0;
         lineBase_q <= '0;
         addr_q     <= '0;
         fBit_q     <= '0;
         pending_q  <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
         load_q     <= 1'b0;
         act_q      <= 1'b0;
         shreg_q    <= '0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         lc_q       <= lc_d;
         line_q     <= line_d;
         lineBase_q <= lineBase_d;
         addr_q     <= addr_d;
         fBit_q     <= fBit_d;
         pending_q  <= pending_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
         load_q     <= fetch;
         act_q      <= fActive;
         dat_q      <= act_q ? datNext : '0;
         if (act_q) begin
            shreg_q <= shNext;
         end
      end
   end

`ifdef SLICE_TEST_PATTERN_EN
   // The channel of the word being fetched is its offset from the line base.
   always_ff @(posedge clk_33) begin
      if (rst) begin
         testMode_q <= 1'b0;
         tpHit_q    <= 1'b0;
      end else begin
         testMode_q <= testMode_d;
         tpHit_q    <= fetch && ((addr_q - lineBase_q) == ADDR_W'(line_q));
      end
   end
`endif

   assign bus.ram_addr         = addr_q;
   assign bus.framebuffer_dat  = dat_q;
   assign bus.framebuffer_sync = (state_q == S_SYNC) || chain;
   assign busy                 = (state_q != S_IDLE);
   assign underrun             = underrun_q;
   assign overrun              = overrun_q;
endmodule
